hyperbus_trans_splitter: RTL

// - Sits between the front-end transaction source and the PHY sequencer, downstream of the config register file.
// - Consumes cfg_i (hyperbus_pkg::hyper_cfg_t) and the per-chip address rules from that file.
// - Decodes the target chip and splits each request into sub-transfers at t_burst_max and chip-end boundaries.
// - Drives trans_active_o, which feeds the register file's trans_active_i and locks config writes while busy.

---
 rtl/hyperbus_pkg.sv | 38 +++
 rtl/hyperbus_chip_decode.sv | 51 +++++
 rtl/hyperbus_trans_splitter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: shared types and constants for the HyperBus controller slice.
// - hyper_cfg_t   : live configuration from the register file
// - rule_t        : per-chip address rule, end_addr is non-inclusive
// - split_state_e : state encoding of the transaction splitter
// - WordBytes     : bytes per HyperBus word
package hyperbus_pkg;

  localparam int RegDataWidth = 32;
  localparam int WordBytes    = 2;
  localparam int WordShift    = $clog2(WordBytes);

  typedef struct packed {
    logic [15:0] t_burst_max;            // max words per sub-transfer, 0 means 1
    logic [4:0]  address_mask_msb;       // highest chip-local address bit kept
    logic [3:0]  t_latency_access;
    logic        en_latency_additional;
  } hyper_cfg_t;

  typedef struct packed {
    logic [RegDataWidth-1:0] idx;
    logic [RegDataWidth-1:0] start_addr;
    logic [RegDataWidth-1:0] end_addr;
  } rule_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } split_state_e;

  // Chip-select index width, never narrower than one bit.
  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hyperbus_chip_decode.sv
// hyperbus_chip_decode: combinational chip-select rule match.
// Ports:
// - addr       in   byte address to decode
// - rules      in   NumChips address rules
// - hit        out  some rule contains addr
// - idx        out  chip select of the lowest matching rule
// - start_addr out  start of the matching range
// - end_addr   out  non-inclusive end of the matching range
module hyperbus_chip_decode
  import hyperbus_pkg::*;
#(
  parameter int NumChips  = 2,
  parameter int AddrWidth = 32,
  parameter int CsWidth   = 1
) (
  input  logic [AddrWidth-1:0]  addr,
  input  rule_t [NumChips-1:0]  rules,
  output logic                  hit,
  output logic [CsWidth-1:0]    idx,
  output logic [AddrWidth-1:0]  start_addr,
  output logic [AddrWidth-1:0]  end_addr
);

  logic [NumChips-1:0] match;
  logic [NumChips-1:0] unused_idx_bits;

  generate
    for (genvar gi = 0; gi < NumChips; gi++) begin : g_match
      assign match[gi] = (AddrWidth'(rules[gi].start_addr) <= addr) &&
                         (addr < AddrWidth'(rules[gi].end_addr));
      assign unused_idx_bits[gi] = ^rules[gi].idx[RegDataWidth-1:CsWidth];
    end
  endgenerate

  // Walk from the top so the lowest matching rule wins.
  always_comb begin
    hit        = 1'b0;
    idx        = '0;
    start_addr = '0;
    end_addr   = '0;
    for (int i = NumChips - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit        = 1'b1;
        idx        = rules[i].idx[CsWidth-1:0];
        start_addr = AddrWidth'(rules[i].start_addr);
        end_addr   = AddrWidth'(rules[i].end_addr);
      end
    end
  end

endmodule

// File: rtl/hyperbus_trans_splitter.sv
// hyperbus_trans_splitter: decodes the target chip of a request and splits it
// into sub-transfers at the burst limit and at chip-end boundaries.
// Ports:
// - clk_i, rst_i                     clock, asynchronous active-high reset
// - cfg_i, chip_rules_i              live config and chip address rules
// - in_valid_i/in_ready_o, in_*      request: byte address, word length, write
// - sub_valid_o/sub_ready_i, sub_*   sub-transfer: chip select, chip offset, words
// - sub_done_i, sub_err_i            sub-transfer completion and error
// - rsp_valid_o/rsp_ready_i, rsp_err_o  per-request response
// - trans_active_o                   busy, locks config writes upstream
module hyperbus_trans_splitter
  import hyperbus_pkg::*;
#(
  parameter int NumChips  = 2,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  hyper_cfg_t                   cfg_i,
  input  rule_t [NumChips-1:0]         chip_rules_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [AddrWidth-1:0]         in_addr_i,
  input  logic [LenWidth-1:0]          in_len_i,
  input  logic                         in_write_i,
  output logic                         sub_valid_o,
  input  logic                         sub_ready_i,
  output logic [cs_width(NumChips)-1:0] sub_cs_o,
  output logic [AddrWidth-1:0]         sub_addr_o,
  output logic [LenWidth-1:0]          sub_len_o,
  output logic                         sub_write_o,
  input  logic                         sub_done_i,
  input  logic                         sub_err_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         rsp_err_o,
  output logic                         trans_active_o
);

  localparam int CsWidth = cs_width(NumChips);

  split_state_e         state;
  logic [AddrWidth-1:0] addr_reg, chip_start_reg, chip_end_reg;
  logic [LenWidth-1:0]  rem_reg, bmax_reg;
  logic [4:0]           msb_reg;
  logic [CsWidth-1:0]   cs_reg;
  logic                 write_reg, err_reg;

  logic                 dec_hit;
  logic [CsWidth-1:0]   dec_idx;
  logic [AddrWidth-1:0] dec_start, dec_end;

  hyperbus_chip_decode #(
    .NumChips (NumChips),
    .AddrWidth(AddrWidth),
    .CsWidth  (CsWidth)
  ) u_decode (
    .addr      (addr_reg),
    .rules     (chip_rules_i),
    .hit       (dec_hit),
    .idx       (dec_idx),
    .start_addr(dec_start),
    .end_addr  (dec_end)
  );

  // Range arithmetic is one bit wider so end - addr and addr + 2*len never alias.
  logic [AddrWidth:0]   dec_span, cur_span, words_wide, addr_sum;
  logic                 dec_short;
  logic [LenWidth-1:0]  words_clamp, len_cur;
  logic [AddrWidth-1:0] mask, offset;

  assign dec_span  = {1'b0, dec_end} - {1'b0, addr_reg};
  // A range with less than one word left at addr cannot carry a sub-transfer.
  assign dec_short = dec_span < (AddrWidth+1)'(WordBytes);

  assign cur_span    = {1'b0, chip_end_reg} - {1'b0, addr_reg};
  assign words_wide  = cur_span >> WordShift;
  assign words_clamp = (|words_wide[AddrWidth:LenWidth]) ? '1 : words_wide[LenWidth-1:0];

  always_comb begin
    len_cur = rem_reg;
    if (bmax_reg < len_cur)    len_cur = bmax_reg;
    if (words_clamp < len_cur) len_cur = words_clamp;
  end

  assign addr_sum = {1'b0, addr_reg} +
                    ({{(AddrWidth+1-LenWidth){1'b0}}, len_cur} << WordShift);

  // Shifting past the top yields 0, so msb = AddrWidth-1 gives an all-ones mask.
  assign mask   = (AddrWidth'(1) << ({1'b0, msb_reg} + 6'd1)) - AddrWidth'(1);
  assign offset = (addr_reg - chip_start_reg) & mask;

  assign in_ready_o     = (state == ST_IDLE);
  assign sub_valid_o    = (state == ST_ISSUE);
  assign sub_cs_o       = sub_valid_o ? cs_reg : '0;
  assign sub_addr_o     = sub_valid_o ? offset : '0;
  assign sub_len_o      = sub_valid_o ? len_cur : '0;
  assign sub_write_o    = sub_valid_o & write_reg;
  assign rsp_valid_o    = (state == ST_RESP);
  assign rsp_err_o      = rsp_valid_o & err_reg;
  assign trans_active_o = (state != ST_IDLE);

  logic unused_inputs;
  assign unused_inputs = ^{in_addr_i[0], cfg_i.t_latency_access, cfg_i.en_latency_additional};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      addr_reg       <= '0;
      chip_start_reg <= '0;
      chip_end_reg   <= '0;
      rem_reg        <= '0;
      bmax_reg       <= '0;
      msb_reg        <= '0;
      cs_reg         <= '0;
      write_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            addr_reg  <= {in_addr_i[AddrWidth-1:1], 1'b0};
            rem_reg   <= in_len_i;
            write_reg <= in_write_i;
            bmax_reg  <= (cfg_i.t_burst_max == '0) ? LenWidth'(1) : LenWidth'(cfg_i.t_burst_max);
            msb_reg   <= cfg_i.address_mask_msb;
            err_reg   <= 1'b0;
            state     <= (in_len_i == '0) ? ST_RESP : ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!dec_hit || dec_short) begin
            err_reg <= 1'b1;
            state   <= ST_RESP;
          end else begin
            cs_reg         <= dec_idx;
            chip_start_reg <= dec_start;
            chip_end_reg   <= dec_end;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sub_ready_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sub_done_i) begin
            err_reg  <= err_reg | sub_err_i;
            rem_reg  <= rem_reg - len_cur;
            addr_reg <= addr_sum[AddrWidth-1:0];
            if (rem_reg == len_cur)
              state <= ST_RESP;
            // A carry out also lands here, so wrap-around is re-decoded.
            else if (addr_sum >= {1'b0, chip_end_reg})
              state <= ST_DECODE;
            else
              state <= ST_ISSUE;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
